// File: rtl/float_pkg.sv
// Shared constants, FSM state type and operand-unpack helper for the float-calc group.
package float_pkg;

  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned MANT_W  = 24;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exponent;
    logic [MANT_W-1:0] mant;
  } fp_fields_t;

  // Mantissa always carries the hidden one; zero/denormal operands take the special path.
  function automatic fp_fields_t fp_unpack(input logic [31:0] x);
    fp_fields_t f;
    f.sign     = x[31];
    f.exponent = x[30:23];
    f.mant     = {1'b1, x[22:0]};
    return f;
  endfunction

endpackage

// File: rtl/float_mul_norm.sv
// Combinational normalise/round/pack stage with special-case priority.
// Round-to-nearest-even is enabled by defining ROUND_NEAREST_EN; default truncates.
module float_mul_norm
  import float_pkg::*;
#(
  parameter int unsigned MANT_W = float_pkg::MANT_W,
  parameter int unsigned BIAS   = float_pkg::BIAS
) (
  input  logic                  sign,
  input  logic [7:0]            e1,
  input  logic [7:0]            e2,
  input  logic [2*MANT_W-1:0]   p,
  output logic [31:0]           result,
  output logic                  overflow,
  output logic                  underflow
);

  logic              inf_op, zero_op;
  logic signed [9:0] e_sum, e_adj, e_fin;
  logic [MANT_W-2:0] frac, frac_fin;
  logic [MANT_W-1:0] frac_inc;
  logic              guard, sticky, round_up;

  assign inf_op  = (e1 == EXP_INF) || (e2 == EXP_INF);
  assign zero_op = (e1 == 8'h00) || (e2 == 8'h00);

`ifdef ROUND_NEAREST_EN
  assign round_up = guard & (sticky | frac[0]);
`else
  logic unused_round;
  assign round_up     = 1'b0;
  assign unused_round = guard ^ sticky;
`endif

  always_comb begin
    e_sum = $signed({2'b00, e1}) + $signed({2'b00, e2}) - $signed(10'(BIAS));
    if (p[2*MANT_W-1]) begin
      frac   = p[2*MANT_W-2 -: MANT_W-1];
      guard  = p[MANT_W-1];
      sticky = |p[MANT_W-2:0];
      e_adj  = e_sum + 10'sd1;
    end else begin
      frac   = p[2*MANT_W-3 -: MANT_W-1];
      guard  = p[MANT_W-2];
      sticky = |p[MANT_W-3:0];
      e_adj  = e_sum;
    end

    // A carry out of the fraction bumps the exponent before the range checks.
    frac_inc = {1'b0, frac} + MANT_W'(round_up);
    if (frac_inc[MANT_W-1]) begin
      frac_fin = '0;
      e_fin    = e_adj + 10'sd1;
    end else begin
      frac_fin = frac_inc[MANT_W-2:0];
      e_fin    = e_adj;
    end

    result    = {sign, 31'h0};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (inf_op) begin
      result   = POS_INF | {sign, 31'h0};
      overflow = 1'b1;
    end else if (zero_op) begin
      result = {sign, 31'h0};
    end else if (e_fin >= 10'sd255) begin
      result   = POS_INF | {sign, 31'h0};
      overflow = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      result    = {sign, 31'h0};
      underflow = 1'b1;
    end else begin
      result = {sign, e_fin[7:0], frac_fin};
    end
  end

endmodule

// File: rtl/float_mul.sv
// Iterative IEEE-754 single-precision multiplier: 24-cycle shift-add, then normalise/pack.
// Optional macro ROUND_NEAREST_EN selects round-to-nearest-even in float_mul_norm.
module float_mul
  import float_pkg::*;
#(
  parameter int unsigned MANT_W = float_pkg::MANT_W,
  parameter int unsigned BIAS   = float_pkg::BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        overflow,
  output logic        underflow,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(MANT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [7:0]          e1_q, e1_d, e2_q, e2_d;
  logic [MANT_W-1:0]   m1_q, m1_d, m2_q, m2_d;
  logic [2*MANT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         s_q, s_d;
  logic                ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;

  fp_fields_t  ua, ub;
  logic [31:0] norm_s;
  logic        norm_ovf, norm_unf;

  assign ua = fp_unpack(A);
  assign ub = fp_unpack(B);

  float_mul_norm #(
    .MANT_W (MANT_W),
    .BIAS   (BIAS)
  ) u_norm (
    .sign      (sign_q),
    .e1        (e1_q),
    .e2        (e2_q),
    .p         (p_q),
    .result    (norm_s),
    .overflow  (norm_ovf),
    .underflow (norm_unf)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = ua.sign ^ ub.sign;
          e1_d   = ua.exponent;
          e2_d   = ub.exponent;
          m1_d   = ua.mant;
          m2_d   = ub.mant;
          p_d    = '0;
          cnt_d  = '0;
          if ((ua.exponent == EXP_INF) || (ub.exponent == EXP_INF) ||
              (ua.exponent == 8'h00) || (ub.exponent == 8'h00)) begin
            state_d = NORM;
          end else begin
            state_d = MULT;
          end
        end
      end
      MULT: begin
        if (m2_q[0]) p_d = p_q + ({{MANT_W{1'b0}}, m1_q} << cnt_q);
        m2_d  = m2_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = NORM;
      end
      NORM: state_d = DONE;
      // Outputs commit on the DONE exit edge so the done pulse coincides with the update.
      DONE: begin
        s_d     = norm_s;
        ovf_d   = norm_ovf;
        unf_d   = norm_unf;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      e1_q    <= '0;
      e2_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      done_q  <= done_d;
    end
  end

  assign S         = s_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/float_mul.md
Name: float_mul

Overview:
- Iterative IEEE-754 single-precision multiplier. It is the inverse-operation companion to the sequential float divider in the ALU float-calc group.
- A shift-add 24x24 mantissa multiply runs over 24 cycles, followed by one normalise/pack cycle.
- A start/done handshake lets the ALU sequencer issue one operation at a time.
- Denormals are flushed to zero. The default result is truncated.

Parameters:
- MANT_W, 24, significand width including hidden bit; fixed for single precision.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request; sampled only in IDLE.
- A  input  32  operand A, IEEE-754 single.
- B  input  32  operand B, IEEE-754 single.
- S  output  32  product; held until the next accepted start.
- overflow  output  1  result exponent >= 255 or an inf/NaN operand; valid with done, held.
- underflow  output  1  result exponent <= 0, flushed to signed zero; held.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when S/overflow/underflow update.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; S=0, overflow=0, underflow=0, busy=0, done=0.
  - All internal registers are cleared.
  - Reset wins over everything, including mid-operation; the in-flight result is discarded and no done pulse is produced.
- IDLE:
  - When start=1, latch A and B, then compute:
    - sign = A[31]^B[31].
    - e1 = A[30:23], e2 = B[30:23].
    - m1 = {1,A[22:0]}, m2 = {1,B[22:0]}.
  - Clear the 48-bit accumulator P and the counter cnt.
  - If either exponent is 0xFF, or either exponent is 0, go to NORM directly (special path, latency 1).
  - Otherwise go to MULT. busy=1.
- MULT:
  - Each cycle: if m2[0] then P += m1<<cnt; m2 >>= 1; cnt += 1.
  - After 24 cycles (cnt==23 on the last add) go to NORM.
- NORM (1 cycle). The sum e = e1+e2-BIAS is computed in 10-bit signed arithmetic.
  - If P[47]: frac = P[46:24], e += 1. Else frac = P[45:22] truncated to P[45:23].
  - Special-case priority, highest first:
    1. Either exponent is 0xFF: S = {sign,8'hFF,23'h0}, overflow=1.
    2. Either exponent is 0: S = {sign,31'h0}, overflow=0.
    3. e >= 255: S = {sign,8'hFF,23'h0}, overflow=1.
    4. e <= 0: S = {sign,31'h0}, underflow=1.
    5. Otherwise: S = {sign,e[7:0],frac}.
  - Then go to DONE.
- DONE:
  - done=1 for exactly this cycle, busy=0, return to IDLE.
  - A start seen in DONE is ignored; start must be seen in IDLE.
- Latency, normal path: start accepted at edge k; done high after edge k+26; the next start is accepted at edge k+27.
- Latency, special path: done high after edge k+2.
- start while busy: ignored, with no queuing. Changing A or B during busy has no effect, because the operands were latched.
- NaN inputs return signed infinity. No NaN is generated; this matches the divider's convention.

Optional Feature:
- Macro ROUND_NEAREST_EN.
- Defined:
  - NORM applies round-to-nearest-even using the guard bit and the OR of the sticky bits below frac.
  - A rounding carry out of frac sets frac=0 and e += 1.
  - The overflow check is performed after rounding.
- Undefined: truncation only, as above.

Decomposition:
- Package float_pkg holds:
  - constants EXP_INF=8'hFF, BIAS=127, MANT_W=24, POS_INF=32'h7F800000;
  - the state enum typedef {IDLE, MULT, NORM, DONE};
  - a helper function to unpack sign, exponent and mantissa.
- One sub-module is natural: float_mul_norm, containing the combinational normalise/round/pack logic and the special-case priority. It is reusable by a future fused multiply-add.

Test Plan:
- 0x40400000 x 0x40000000 -> S=0x40C00000, overflow=0, done exactly 26 cycles after start; busy high throughout.
- 0x3FC00000 x 0x3FC00000 -> S=0x40100000, which exercises the P[47] normalise path.
- 0x7F000000 x 0x7F000000 -> S=0x7F800000, overflow=1. Also 0x7F800000 x 0x3F800000 -> S=0x7F800000, overflow=1, done after 2 cycles.
- 0x00000000 x 0xC0000000 -> S=0x80000000, overflow=0. Also 0x00800000 x 0x00800000 -> S=0x00000000, underflow=1.
- 0x3FC00001 x 0x3F800001 -> S=0x3FC00002 without ROUND_NEAREST_EN; S=0x3FC00003 with it.
- Pulse start with new operands at cycle 10 of an operation -> ignored, first result unchanged. Drive rst_n=0 at cycle 12 -> all outputs 0, state IDLE, no done pulse; the next start completes normally.
